// File: rtl/qos_wrr_scheduler_pkg.sv
// Shared constants, FSM encoding and weight helper for the four-queue WRR scheduler.
package qos_wrr_scheduler_pkg;

    localparam int unsigned NumQueues = 4;
    localparam int unsigned QidW      = 2;
    localparam int unsigned PtrW      = 8;
    localparam int unsigned AddrW     = 10;
    localparam int unsigned CntW      = 9;
    localparam int unsigned MemWords  = 1024;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArb  = 2'd1,
        StSend = 2'd2
    } state_e;

    // A zero weight would starve the queue forever, so it is served as weight 1.
    function automatic logic [3:0] eff_weight(input logic [3:0] w);
        return (w == 4'd0) ? 4'd1 : w;
    endfunction

endpackage

// File: rtl/qos_wrr_arbiter.sv
// Rotate-priority pick: first eligible queue at or after rr_ptr, cyclic over four queues.
module qos_wrr_arbiter
    import qos_wrr_scheduler_pkg::*;
(
    input  logic [NumQueues-1:0] eligible,
    input  logic [QidW-1:0]      rr_ptr,
    output logic [QidW-1:0]      grant,
    output logic                 any_valid
);

    logic             found;
    logic [QidW-1:0]  idx;

    always_comb begin
        grant     = rr_ptr;
        found     = 1'b0;
        idx       = rr_ptr;
        any_valid = |eligible;
        for (int i = 0; i < NumQueues; i++) begin
            idx = rr_ptr + QidW'(i);
            if (!found && eligible[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qos_wrr_scheduler.sv
// Four-queue shared-memory packet buffer with store-and-forward weighted round-robin dequeue.
module qos_wrr_scheduler
    import qos_wrr_scheduler_pkg::*;
#(
    parameter logic [3:0] W0 = 4'd8,
    parameter logic [3:0] W1 = 4'd4,
    parameter logic [3:0] W2 = 4'd2,
    parameter logic [3:0] W3 = 4'd1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_wr,
    input  logic [QidW-1:0]      in_qid,
    input  logic                 in_eop,
    output logic                 wr_en,
    output logic [AddrW-1:0]     wr_addr,
    input  logic                 out_rdy,
    output logic                 rd_en,
    output logic [AddrW-1:0]     rd_addr,
    output logic [QidW-1:0]      rd_qid,
    output logic                 rd_eop,
    output logic [NumQueues-1:0] full,
    output logic [NumQueues-1:0] empty,
    output logic                 drop
);

    logic [PtrW-1:0]     wp_q   [NumQueues];
    logic [PtrW-1:0]     wp_d   [NumQueues];
    logic [PtrW-1:0]     rp_q   [NumQueues];
    logic [PtrW-1:0]     rp_d   [NumQueues];
    logic [CntW-1:0]     wcnt_q [NumQueues];
    logic [CntW-1:0]     wcnt_d [NumQueues];
    logic [CntW-1:0]     pcnt_q [NumQueues];
    logic [CntW-1:0]     pcnt_d [NumQueues];
    logic [MemWords-1:0] eop_q;

    state_e          state_q;
    logic [QidW-1:0] cur_q;
    logic [QidW-1:0] rr_q;
    logic [3:0]      credit_q;

    logic [NumQueues-1:0] eligible, winc, wdec, pinc, pdec;
    logic [QidW-1:0]      grant;
    logic                 any_valid;

    function automatic logic [3:0] weight_of(input logic [QidW-1:0] q);
        logic [3:0] w;
        unique case (q)
            2'd0:    w = W0;
            2'd1:    w = W1;
            2'd2:    w = W2;
            default: w = W3;
        endcase
        return eff_weight(w);
    endfunction

    // Full is judged on the registered count, so a same-cycle read never rescues a write.
    always_comb begin
        for (int q = 0; q < NumQueues; q++) begin
            full[q]     = (wcnt_q[q] == CntW'(256));
            empty[q]    = (wcnt_q[q] == '0);
            eligible[q] = (pcnt_q[q] != '0);
        end
        wr_en   = !reset && in_wr && !full[in_qid];
        drop    = !reset && in_wr && full[in_qid];
        wr_addr = {in_qid, wp_q[in_qid]};
        rd_en   = !reset && (state_q == StSend) && out_rdy;
        rd_addr = {cur_q, rp_q[cur_q]};
        rd_qid  = cur_q;
        rd_eop  = rd_en && eop_q[rd_addr];
    end

    always_comb begin
        winc = '0;
        wdec = '0;
        pinc = '0;
        pdec = '0;
        for (int q = 0; q < NumQueues; q++) begin
            winc[q]   = wr_en && (in_qid == QidW'(q));
            wdec[q]   = rd_en && (cur_q == QidW'(q));
            pinc[q]   = winc[q] && in_eop;
            pdec[q]   = wdec[q] && rd_eop;
            wp_d[q]   = wp_q[q] + PtrW'(winc[q]);
            rp_d[q]   = rp_q[q] + PtrW'(wdec[q]);
            wcnt_d[q] = wcnt_q[q] + CntW'(winc[q]) - CntW'(wdec[q]);
            pcnt_d[q] = pcnt_q[q] + CntW'(pinc[q]) - CntW'(pdec[q]);
        end
    end

    qos_wrr_arbiter u_arbiter (
        .eligible  (eligible),
        .rr_ptr    (rr_q),
        .grant     (grant),
        .any_valid (any_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int q = 0; q < NumQueues; q++) begin
                wp_q[q]   <= '0;
                rp_q[q]   <= '0;
                wcnt_q[q] <= '0;
                pcnt_q[q] <= '0;
            end
            eop_q <= '0;
        end else begin
            for (int q = 0; q < NumQueues; q++) begin
                wp_q[q]   <= wp_d[q];
                rp_q[q]   <= rp_d[q];
                wcnt_q[q] <= wcnt_d[q];
                pcnt_q[q] <= pcnt_d[q];
            end
            if (wr_en) begin
                eop_q[wr_addr] <= in_eop;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cur_q    <= '0;
            rr_q     <= '0;
            credit_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        state_q <= StArb;
                    end
                end
                StArb: begin
                    if (any_valid) begin
                        cur_q   <= grant;
                        state_q <= StSend;
                        // Exhausted credit also reloads, else a lone queue revisited would stall at 0.
                        if (grant != cur_q || credit_q == '0) begin
                            credit_q <= weight_of(grant);
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StSend: begin
                    if (rd_en && rd_eop) begin
                        credit_q <= credit_q - 4'd1;
                        state_q  <= StArb;
                        if (credit_q == 4'd1 || pcnt_d[cur_q] == '0) begin
                            rr_q <= cur_q + 2'd1;
                        end else begin
                            rr_q <= cur_q;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_qos_wrr_scheduler.sv
// Scoreboard bench: stimulus pushes expected writes/reads, a negedge monitor pops and compares.
module tb_qos_wrr_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_wr;
    logic [1:0] in_qid;
    logic       in_eop;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic       out_rdy;
    logic       rd_en;
    logic [9:0] rd_addr;
    logic [1:0] rd_qid;
    logic       rd_eop;
    logic [3:0] full;
    logic [3:0] empty;
    logic       drop;

    qos_wrr_scheduler dut (
        .clk     (clk),
        .reset   (reset),
        .in_wr   (in_wr),
        .in_qid  (in_qid),
        .in_eop  (in_eop),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .out_rdy (out_rdy),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_qid  (rd_qid),
        .rd_eop  (rd_eop),
        .full    (full),
        .empty   (empty),
        .drop    (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       drp;
        logic [9:0] addr;
    } wr_exp_t;

    typedef struct {
        logic [9:0] addr;
        logic       eop;
    } rd_exp_t;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];
    wr_exp_t we;
    rd_exp_t re;
    logic [7:0] wp_m[4];
    logic [7:0] rp_m[4];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!reset && in_wr) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 32'(in_wr), 32'(0));
            end else begin
                we = wr_q.pop_front();
                check("wr_en", 32'(wr_en), 32'(we.en));
                check("drop", 32'(drop), 32'(we.drp));
                check("wr_addr", 32'(wr_addr), 32'(we.addr));
            end
        end
        if (!reset && rd_en) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 32'(rd_addr), 32'h3ff_ffff);
            end else begin
                re = rd_q.pop_front();
                check("rd_addr", 32'(rd_addr), 32'(re.addr));
                check("rd_eop", 32'(rd_eop), 32'(re.eop));
                check("rd_qid", 32'(rd_qid), 32'(re.addr[9:8]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        in_wr   = 1'b0;
        in_qid  = 2'd0;
        in_eop  = 1'b0;
        out_rdy = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        for (int q = 0; q < 4; q++) begin
            wp_m[q] = 8'd0;
            rp_m[q] = 8'd0;
        end
        wr_q.delete();
        rd_q.delete();
        #1;
    endtask

    task automatic write_word(input logic [1:0] q, input logic eop, input logic exp_en);
        wr_exp_t e;
        e.en   = exp_en;
        e.drp  = !exp_en;
        e.addr = {q, wp_m[q]};
        wr_q.push_back(e);
        if (exp_en) wp_m[q] = wp_m[q] + 8'd1;
        in_wr  = 1'b1;
        in_qid = q;
        in_eop = eop;
        cyc();
        in_wr  = 1'b0;
        in_eop = 1'b0;
    endtask

    task automatic expect_read(input logic [1:0] q, input logic eop);
        rd_exp_t e;
        e.addr = {q, rp_m[q]};
        e.eop  = eop;
        rd_q.push_back(e);
        rp_m[q] = rp_m[q] + 8'd1;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (rd_q.size() != 0 && n < limit) begin
            cyc();
            n++;
        end
        check(name, 32'(rd_q.size()), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ord[$];
        do_reset();

        // Reset state held for 10 idle cycles
        check("reset_rd_addr", 32'(rd_addr), 32'h000);
        check("reset_rd_qid", 32'(rd_qid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("reset_empty", 32'(empty), 32'hf);
            check("reset_full", 32'(full), 32'h0);
            check("reset_rd_en", 32'(rd_en), 32'd0);
            check("reset_drop", 32'(drop), 32'd0);
            cyc();
        end

        // Single 3-word packet to q2: 0x200..0x202, eop on last
        out_rdy = 1'b1;
        expect_read(2'd2, 1'b0);
        expect_read(2'd2, 1'b0);
        expect_read(2'd2, 1'b1);
        write_word(2'd2, 1'b0, 1'b1);
        write_word(2'd2, 1'b0, 1'b1);
        write_word(2'd2, 1'b1, 1'b1);
        wait_drain("single_drain", 50);
        cyc();
        check("single_empty", 32'(empty), 32'hf);

        // Weighting: 10 one-word packets per queue, loaded while stalled
        do_reset();
        for (int q = 0; q < 4; q++)
            for (int k = 0; k < 10; k++)
                write_word(2'(q), 1'b1, 1'b1);
        ord = '{0,0,0,0,0,0,0,0, 1,1,1,1, 2,2, 3,
                0,0, 1,1,1,1, 2,2, 3,
                1,1, 2,2, 3,
                2,2, 3,
                2,2, 3,
                3,3,3,3,3};
        foreach (ord[i]) expect_read(2'(ord[i]), 1'b1);
        out_rdy = 1'b1;
        wait_drain("weight_drain", 400);
        cyc();
        check("weight_empty", 32'(empty), 32'hf);

        // Overflow on q1
        do_reset();
        for (int i = 0; i < 256; i++) write_word(2'd1, 1'b0, 1'b1);
        check("ovf_full", 32'(full), 32'h2);
        check("ovf_empty", 32'(empty), 32'hd);
        write_word(2'd1, 1'b0, 1'b0);
        check("ovf_full_hold", 32'(full), 32'h2);

        // Wrap: 300 one-word packets through q0
        do_reset();
        out_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            expect_read(2'd0, 1'b1);
            write_word(2'd0, 1'b1, 1'b1);
        end
        wait_drain("wrap_drain", 1000);
        cyc();
        check("wrap_empty", 32'(empty), 32'hf);

        // Stall mid-packet on q3
        do_reset();
        for (int i = 0; i < 4; i++) expect_read(2'd3, (i == 3));
        for (int i = 0; i < 4; i++) write_word(2'd3, (i == 3), 1'b1);
        repeat (4) cyc();
        out_rdy = 1'b1;
        cyc();
        cyc();
        out_rdy = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_rd_en", 32'(rd_en), 32'd0);
            check("stall_rd_addr", 32'(rd_addr), 32'h302);
            check("stall_rd_qid", 32'(rd_qid), 32'd3);
            cyc();
        end
        out_rdy = 1'b1;
        wait_drain("stall_drain", 20);

        // Reset asserted mid-packet abandons it
        do_reset();
        for (int i = 0; i < 3; i++) write_word(2'd0, (i == 2), 1'b1);
        repeat (4) cyc();
        expect_read(2'd0, 1'b0);
        out_rdy = 1'b1;
        cyc();
        reset   = 1'b1;
        out_rdy = 1'b0;
        cyc();
        reset = 1'b0;
        #1;
        check("midrst_empty", 32'(empty), 32'hf);
        check("midrst_full", 32'(full), 32'h0);
        check("midrst_pending", 32'(rd_q.size()), 32'd0);
        out_rdy = 1'b1;
        repeat (4) begin
            check("midrst_rd_en", 32'(rd_en), 32'd0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
